gfx_wbm_rw_bridge: RTL and testbench

- Downstream end of the GFX read/write arbiter. Accepts the single muxed read or write request it produces and runs one Wishbone classic cycle per request on the memory bus.
- Returns read data and a one-cycle ack to the arbiter, which routes them to the winning master.
- Adds a bus-error path and a watchdog timeout, so a dead slave cannot hang the pipeline.

---
 rtl/gfx_pkg.sv | 10 +
 rtl/gfx_wbm_watchdog.sv | 31 +++
 rtl/gfx_wbm_rw_bridge.sv | 138 +++++++++++++
 tb/tb_gfx_wbm_rw_bridge.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gfx_pkg.sv
// Shared GFX memory-path types: Wishbone master FSM states and the fixed
// classic-cycle encodings driven on cti/bte.
package gfx_pkg;

   typedef enum logic [1:0] {WB_IDLE, WB_BUS, WB_DONE} wbm_rw_state_t;

   localparam logic [2:0] CTI_CLASSIC = 3'b000;
   localparam logic [1:0] BTE_LINEAR  = 2'b00;

endpackage

// File: rtl/gfx_wbm_watchdog.sv
// Bus-cycle watchdog: counts cycles while enabled, flags expiry on the cycle
// whose increment would reach all-ones, then wraps back to zero.
module gfx_wbm_watchdog #(
   parameter int TO_BITS = 8
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic clr_i,
   input  logic en_i,
   output logic expired_o
);

   localparam logic [TO_BITS-1:0] ONE = {{(TO_BITS-1){1'b0}}, 1'b1};

   logic [TO_BITS-1:0] r_cnt;
   logic [TO_BITS-1:0] w_next;

   assign w_next    = r_cnt + ONE;
   assign expired_o = en_i & (&w_next);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_cnt <= '0;
      end else if (clr_i || expired_o) begin
         r_cnt <= '0;
      end else if (en_i) begin
         r_cnt <= w_next;
      end
   end

endmodule

// File: rtl/gfx_wbm_rw_bridge.sv
// Runs one Wishbone classic cycle per muxed arbiter request and returns read
// data plus a one-cycle ack; bus errors and watchdog expiry also complete the cycle.
module gfx_wbm_rw_bridge
   import gfx_pkg::*;
#(
   parameter int MDW     = 256,
   parameter int TO_BITS = 8
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               read_request_i,
   input  logic               write_request_i,
   input  logic [31:0]        addr_i,
   input  logic               we_i,
   input  logic [MDW/8-1:0]   sel_i,
   input  logic [MDW-1:0]     dat_i,
   output logic [MDW-1:0]     dat_o,
   output logic               ack_o,
   output logic               wbm_cyc_o,
   output logic               wbm_stb_o,
   output logic [2:0]         wbm_cti_o,
   output logic [1:0]         wbm_bte_o,
   output logic               wbm_we_o,
   output logic [31:0]        wbm_adr_o,
   output logic [MDW/8-1:0]   wbm_sel_o,
   output logic [MDW-1:0]     wbm_dat_o,
   input  logic [MDW-1:0]     wbm_dat_i,
   input  logic               wbm_ack_i,
   input  logic               wbm_err_i,
   input  logic               err_clr_i,
   output logic               bus_err_o,
   output logic               timeout_o,
   output logic [1:0]         dbg_state_o
);

   // Handshake: a request is taken only in IDLE; completion is ack_o high for
   // exactly the DONE cycle, and requests seen in BUS or DONE are ignored.
   wbm_rw_state_t      r_state;
   logic               r_cyc;
   logic               r_we;
   logic [31:0]        r_adr;
   logic [MDW/8-1:0]   r_sel;
   logic [MDW-1:0]     r_wdat;
   logic [MDW-1:0]     r_rdat;
   logic               r_bus_err;
   logic               r_timeout;

   logic w_req;
   logic w_in_bus;
   logic w_start;
   logic w_expired;
   logic w_err_set;
   logic w_to_set;
   logic w_unused_we;

   // Direction comes from the request lines; the arbiter's we is redundant.
   assign w_unused_we = we_i;

   assign w_req     = read_request_i | write_request_i;
   assign w_in_bus  = (r_state == WB_BUS);
   assign w_start   = (r_state == WB_IDLE) & w_req;
   assign w_err_set = w_in_bus & wbm_err_i;
   assign w_to_set  = w_in_bus & ~wbm_err_i & ~wbm_ack_i & w_expired;

   gfx_wbm_watchdog #(.TO_BITS(TO_BITS)) u_watchdog (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .clr_i     (w_start),
      .en_i      (w_in_bus),
      .expired_o (w_expired)
   );

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state <= WB_IDLE;
         r_cyc   <= 1'b0;
         r_we    <= 1'b0;
         r_adr   <= '0;
         r_sel   <= '0;
         r_wdat  <= '0;
         r_rdat  <= '0;
      end else begin
         case (r_state)
            WB_IDLE: begin
               if (w_req) begin
                  r_adr   <= addr_i;
                  r_sel   <= sel_i;
                  r_wdat  <= dat_i;
                  r_we    <= write_request_i;
                  r_cyc   <= 1'b1;
                  r_state <= WB_BUS;
               end
            end
            WB_BUS: begin
               if (wbm_err_i || w_expired) begin
                  r_cyc   <= 1'b0;
                  if (!r_we) r_rdat <= '0;
                  r_state <= WB_DONE;
               end else if (wbm_ack_i) begin
                  r_cyc   <= 1'b0;
                  if (!r_we) r_rdat <= wbm_dat_i;
                  r_state <= WB_DONE;
               end
            end
            WB_DONE: r_state <= WB_IDLE;
            default: r_state <= WB_IDLE;
         endcase
      end
   end

   // A set event in the same cycle as a clear keeps the flag high.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_bus_err <= 1'b0;
         r_timeout <= 1'b0;
      end else begin
         if (w_err_set)      r_bus_err <= 1'b1;
         else if (err_clr_i) r_bus_err <= 1'b0;
         if (w_to_set)       r_timeout <= 1'b1;
         else if (err_clr_i) r_timeout <= 1'b0;
      end
   end

   assign dat_o       = r_rdat;
   assign ack_o       = (r_state == WB_DONE);
   assign wbm_cyc_o   = r_cyc;
   assign wbm_stb_o   = r_cyc;
   assign wbm_cti_o   = CTI_CLASSIC;
   assign wbm_bte_o   = BTE_LINEAR;
   assign wbm_we_o    = r_we;
   assign wbm_adr_o   = r_adr;
   assign wbm_sel_o   = r_sel;
   assign wbm_dat_o   = r_wdat;
   assign bus_err_o   = r_bus_err;
   assign timeout_o   = r_timeout;
   assign dbg_state_o = r_state;

endmodule

// File: tb/tb_gfx_wbm_rw_bridge.sv
// Directed bench for gfx_wbm_rw_bridge with a 4-bit watchdog so the timeout
// path is reachable in a few cycles.
module tb_gfx_wbm_rw_bridge;
  import gfx_pkg::*;

  localparam int MDW = 256;

  logic             clk = 1'b0;
  logic             rst;
  logic             read_request_i;
  logic             write_request_i;
  logic [31:0]      addr_i;
  logic             we_i;
  logic [MDW/8-1:0] sel_i;
  logic [MDW-1:0]   dat_i;
  logic [MDW-1:0]   dat_o;
  logic             ack_o;
  logic             wbm_cyc_o;
  logic             wbm_stb_o;
  logic [2:0]       wbm_cti_o;
  logic [1:0]       wbm_bte_o;
  logic             wbm_we_o;
  logic [31:0]      wbm_adr_o;
  logic [MDW/8-1:0] wbm_sel_o;
  logic [MDW-1:0]   wbm_dat_o;
  logic [MDW-1:0]   wbm_dat_i;
  logic             wbm_ack_i;
  logic             wbm_err_i;
  logic             err_clr_i;
  logic             bus_err_o;
  logic             timeout_o;
  logic [1:0]       dbg_state_o;

  int n_checks = 0;
  int n_errors = 0;

  localparam logic [MDW-1:0]   PAT_A5   = {32{8'hA5}};
  localparam logic [MDW-1:0]   PAT_5A   = {32{8'h5A}};
  localparam logic [MDW-1:0]   PAT_C3   = {32{8'hC3}};
  localparam logic [MDW-1:0]   PAT_FF   = {32{8'hFF}};
  localparam logic [MDW-1:0]   PAT_WR   = {8{32'h1234_5678}};
  localparam logic [MDW/8-1:0] SEL_ALL  = {(MDW/8){1'b1}};
  localparam logic [MDW/8-1:0] SEL_LOW4 = 32'h0000_000F;

  // clock/reset block
  always #5 clk = ~clk;

  gfx_wbm_rw_bridge #(.MDW(MDW), .TO_BITS(4)) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .read_request_i  (read_request_i),
    .write_request_i (write_request_i),
    .addr_i          (addr_i),
    .we_i            (we_i),
    .sel_i           (sel_i),
    .dat_i           (dat_i),
    .dat_o           (dat_o),
    .ack_o           (ack_o),
    .wbm_cyc_o       (wbm_cyc_o),
    .wbm_stb_o       (wbm_stb_o),
    .wbm_cti_o       (wbm_cti_o),
    .wbm_bte_o       (wbm_bte_o),
    .wbm_we_o        (wbm_we_o),
    .wbm_adr_o       (wbm_adr_o),
    .wbm_sel_o       (wbm_sel_o),
    .wbm_dat_o       (wbm_dat_o),
    .wbm_dat_i       (wbm_dat_i),
    .wbm_ack_i       (wbm_ack_i),
    .wbm_err_i       (wbm_err_i),
    .err_clr_i       (err_clr_i),
    .bus_err_o       (bus_err_o),
    .timeout_o       (timeout_o),
    .dbg_state_o     (dbg_state_o)
  );

  task automatic check(input string tag, input logic [MDW-1:0] got, input logic [MDW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // drive and sample 1 time unit after the active edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input logic rd, input logic wr, input logic [31:0] a,
                           input logic [MDW/8-1:0] s, input logic [MDW-1:0] d);
    read_request_i  = rd;
    write_request_i = wr;
    we_i            = wr;
    addr_i          = a;
    sel_i           = s;
    dat_i           = d;
  endtask

  task automatic drop_req();
    read_request_i  = 1'b0;
    write_request_i = 1'b0;
    we_i            = 1'b0;
  endtask

  task automatic slave(input logic ack, input logic err, input logic [MDW-1:0] d);
    wbm_ack_i = ack;
    wbm_err_i = err;
    wbm_dat_i = d;
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_cyc"},   wbm_cyc_o, 0);
    check({pfx, "_stb"},   wbm_stb_o, 0);
    check({pfx, "_we"},    wbm_we_o, 0);
    check({pfx, "_adr"},   wbm_adr_o, 0);
    check({pfx, "_sel"},   wbm_sel_o, 0);
    check({pfx, "_wdat"},  wbm_dat_o, 0);
    check({pfx, "_rdat"},  dat_o, 0);
    check({pfx, "_ack"},   ack_o, 0);
    check({pfx, "_berr"},  bus_err_o, 0);
    check({pfx, "_tmo"},   timeout_o, 0);
    check({pfx, "_state"}, dbg_state_o, WB_IDLE);
  endtask

  initial begin
    rst = 1'b1;
    err_clr_i = 1'b0;
    drop_req();
    addr_i = '0; sel_i = '0; dat_i = '0;
    slave(1'b0, 1'b0, '0);
    tick(); tick();
    check_reset_outputs("rst");
    check("rst_cti", wbm_cti_o, 3'b000);
    check("rst_bte", wbm_bte_o, 2'b00);
    rst = 1'b0;
    tick();

    // read, zero-wait slave
    drive_req(1'b1, 1'b0, 32'h0000_1000, SEL_ALL, PAT_5A);
    tick();
    check("rd_cyc", wbm_cyc_o, 1);
    check("rd_stb", wbm_stb_o, 1);
    check("rd_we", wbm_we_o, 0);
    check("rd_adr", wbm_adr_o, 32'h1000);
    check("rd_sel", wbm_sel_o, SEL_ALL);
    check("rd_ack_early", ack_o, 0);
    slave(1'b1, 1'b0, PAT_A5);
    tick();
    check("rd_ack", ack_o, 1);
    check("rd_dat", dat_o, PAT_A5);
    check("rd_cyc_drop", wbm_cyc_o, 0);
    slave(1'b0, 1'b0, '0);
    drop_req();
    tick();
    check("rd_ack_pulse", ack_o, 0);
    check("rd_cyc_e3", wbm_cyc_o, 0);
    tick();
    check("rd_no_reissue", wbm_cyc_o, 0);

    // write, 3 wait states
    drive_req(1'b0, 1'b1, 32'h0000_2000, SEL_LOW4, PAT_WR);
    tick();
    drop_req();
    for (int i = 0; i < 4; i++) begin
      check($sformatf("wr_cyc%0d", i), wbm_cyc_o, 1);
      check($sformatf("wr_we%0d", i), wbm_we_o, 1);
      check($sformatf("wr_adr%0d", i), wbm_adr_o, 32'h2000);
      check($sformatf("wr_sel%0d", i), wbm_sel_o, SEL_LOW4);
      check($sformatf("wr_wdat%0d", i), wbm_dat_o, PAT_WR);
      check($sformatf("wr_ack%0d", i), ack_o, 0);
      if (i == 3) slave(1'b1, 1'b0, PAT_FF);
      tick();
    end
    check("wr_ack", ack_o, 1);
    check("wr_dat_kept", dat_o, PAT_A5);
    check("wr_cyc_drop", wbm_cyc_o, 0);
    slave(1'b0, 1'b0, '0);
    tick();
    check("wr_ack_pulse", ack_o, 0);

    // slave error with ack on a read
    drive_req(1'b1, 1'b0, 32'h0000_3000, SEL_ALL, '0);
    tick();
    drop_req();
    slave(1'b1, 1'b1, PAT_FF);
    tick();
    check("err_ack", ack_o, 1);
    check("err_dat", dat_o, 0);
    check("err_flag", bus_err_o, 1);
    check("err_cyc", wbm_cyc_o, 0);
    slave(1'b0, 1'b0, '0);
    tick(); tick();
    check("err_sticky", bus_err_o, 1);
    err_clr_i = 1'b1;
    tick();
    err_clr_i = 1'b0;
    check("err_clr", bus_err_o, 0);

    // error coinciding with clear: flag stays set
    drive_req(1'b1, 1'b0, 32'h0000_3100, SEL_ALL, '0);
    tick();
    drop_req();
    slave(1'b0, 1'b1, '0);
    err_clr_i = 1'b1;
    tick();
    err_clr_i = 1'b0;
    slave(1'b0, 1'b0, '0);
    check("err_set_wins", bus_err_o, 1);
    err_clr_i = 1'b1;
    tick();
    err_clr_i = 1'b0;
    check("err_clr2", bus_err_o, 0);

    // read returning data so the timeout zeroing is visible
    drive_req(1'b1, 1'b0, 32'h0000_4000, SEL_ALL, '0);
    tick();
    drop_req();
    slave(1'b1, 1'b0, PAT_5A);
    tick();
    check("rd2_dat", dat_o, PAT_5A);
    slave(1'b0, 1'b0, '0);
    tick();

    // timeout: silent slave, request dropped during BUS
    drive_req(1'b1, 1'b0, 32'h0000_5000, SEL_ALL, '0);
    tick();
    drop_req();
    for (int i = 0; i < 14; i++) tick();
    check("to_cyc_15", wbm_cyc_o, 1);
    check("to_ack_early", ack_o, 0);
    check("to_flag_early", timeout_o, 0);
    tick();
    check("to_cyc_drop", wbm_cyc_o, 0);
    check("to_ack", ack_o, 1);
    check("to_flag", timeout_o, 1);
    check("to_dat", dat_o, 0);
    check("to_no_berr", bus_err_o, 0);
    tick();
    check("to_idle", dbg_state_o, WB_IDLE);
    drive_req(1'b1, 1'b0, 32'h0000_6000, SEL_ALL, '0);
    tick();
    drop_req();
    check("to_next_cyc", wbm_cyc_o, 1);
    check("to_next_adr", wbm_adr_o, 32'h6000);
    slave(1'b1, 1'b0, PAT_C3);
    tick();
    check("to_next_ack", ack_o, 1);
    check("to_next_dat", dat_o, PAT_C3);
    check("to_sticky", timeout_o, 1);
    slave(1'b0, 1'b0, '0);
    err_clr_i = 1'b1;
    tick();
    err_clr_i = 1'b0;
    check("to_clr", timeout_o, 0);

    // request held through DONE, dropped one cycle later
    drive_req(1'b0, 1'b1, 32'h0000_7000, SEL_ALL, PAT_WR);
    tick();
    check("hold_cyc", wbm_cyc_o, 1);
    slave(1'b1, 1'b0, '0);
    tick();
    check("hold_ack", ack_o, 1);
    slave(1'b0, 1'b0, '0);
    tick();
    check("hold_cyc_e3", wbm_cyc_o, 0);
    drop_req();
    tick();
    check("hold_no_reissue", wbm_cyc_o, 0);
    check("hold_state", dbg_state_o, WB_IDLE);
    tick();
    check("hold_no_reissue2", wbm_cyc_o, 0);

    // asynchronous reset mid-BUS
    drive_req(1'b1, 1'b0, 32'h0000_8000, SEL_ALL, PAT_WR);
    tick();
    check("mid_cyc", wbm_cyc_o, 1);
    rst = 1'b1;
    drop_req();
    #1;
    check_reset_outputs("arst");
    tick();
    rst = 1'b0;
    tick();
    check("arst_ack", ack_o, 0);
    check("arst_cyc", wbm_cyc_o, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
